// File: rtl/ntt_seq_ctrl.sv
// Stage/butterfly slot sequencer for the unified Kyber/Dilithium NTT core.
// Optional inter-stage idle gap enabled by NTT_SEQ_STAGE_BUBBLE_EN.
module ntt_seq_ctrl #(
  parameter int PIPE_DEPTH = 6,
  parameter int BUBBLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       kd_sel,
  input  logic       inv,
  input  logic       stall,
  output logic       busy,
  output logic       valid,
  output logic [2:0] p,
  output logic [6:0] k,
  output logic [6:0] j,
  output logic       KD_mode,
  output logic [3:0] Run_mode,
  output logic       stage_last,
  output logic       done
);

  localparam int CMAX = (PIPE_DEPTH > BUBBLE_CYC) ? PIPE_DEPTH : BUBBLE_CYC;
  localparam int CW = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_BUBBLE, S_DRAIN, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [2:0]    p_n;
  logic [6:0]    k_n, j_n;
  logic          valid_n, stage_last_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          inv_q, kd_n, inv_n;
  logic          slot_end, j_end, last_stage;
  logic [3:0]    base;

  // log2 of groups per stage; Kyber packs two radix-2 layers per stage
  function automatic logic [2:0] glog(input logic kdv, input logic [2:0] pv);
    logic [2:0] r;
    r = 3'd0;
    if (kdv) begin
      r = 3'd7 - pv;
    end else begin
      case (pv)
        3'd2:    r = 3'd1;
        3'd1:    r = 3'd3;
        3'd0:    r = 3'd5;
        default: r = 3'd0;
      endcase
    end
    return r;
  endfunction

  function automatic logic [6:0] gmax(input logic kdv, input logic [2:0] pv);
    logic [7:0] g;
    g = (8'd1 << glog(kdv, pv)) - 8'd1;
    return g[6:0];
  endfunction

  function automatic logic [6:0] bmax(input logic kdv, input logic [2:0] pv);
    logic [2:0] bl;
    logic [7:0] b;
    bl = kdv ? pv : (3'd6 - glog(kdv, pv));
    b = (8'd1 << bl) - 8'd1;
    return b[6:0];
  endfunction

  function automatic logic [2:0] p_first(input logic kdv, input logic iv);
    return iv ? 3'd0 : (kdv ? 3'd7 : 3'd3);
  endfunction

  function automatic logic [2:0] p_last(input logic kdv, input logic iv);
    return iv ? (kdv ? 3'd7 : 3'd3) : 3'd0;
  endfunction

  assign j_end = (j == bmax(KD_mode, p));
  assign slot_end = j_end && (k == gmax(KD_mode, p));
  assign last_stage = (p == p_last(KD_mode, inv_q));

  always_comb begin
    state_n = state;
    p_n = p;
    k_n = k;
    j_n = j;
    valid_n = 1'b0;
    cnt_n = cnt;
    kd_n = KD_mode;
    inv_n = inv_q;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_RUN;
          kd_n = kd_sel;
          inv_n = inv;
          p_n = p_first(kd_sel, inv);
          k_n = 7'd0;
          j_n = 7'd0;
          valid_n = 1'b1;
        end
      end
      S_RUN: begin
        // the held slot has always been issued already
        if (slot_end && last_stage) begin
          state_n = S_DRAIN;
          cnt_n = CW'(PIPE_DEPTH - 1);
        end else if (stall) begin
          valid_n = 1'b0;
        end else if (slot_end) begin
          p_n = inv_q ? p + 3'd1 : p - 3'd1;
          k_n = 7'd0;
          j_n = 7'd0;
`ifdef NTT_SEQ_STAGE_BUBBLE_EN
          state_n = S_BUBBLE;
          cnt_n = CW'(BUBBLE_CYC - 1);
`else
          valid_n = 1'b1;
`endif
        end else if (j_end) begin
          k_n = k + 7'd1;
          j_n = 7'd0;
          valid_n = 1'b1;
        end else begin
          j_n = j + 7'd1;
          valid_n = 1'b1;
        end
      end
`ifdef NTT_SEQ_STAGE_BUBBLE_EN
      S_BUBBLE: begin
        if (cnt == '0) begin
          state_n = S_RUN;
          valid_n = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
`endif
      S_DRAIN: begin
        if (cnt == '0) state_n = S_DONE;
        else cnt_n = cnt - CW'(1);
      end
      S_DONE: begin
        state_n = S_IDLE;
        p_n = 3'd0;
        k_n = 7'd0;
        j_n = 7'd0;
      end
      default: state_n = S_IDLE;
    endcase
    stage_last_n = valid_n &&
                   (k_n == gmax(kd_n, p_n)) &&
                   (j_n == bmax(kd_n, p_n));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      p <= 3'd0;
      k <= 7'd0;
      j <= 7'd0;
      valid <= 1'b0;
      stage_last <= 1'b0;
      cnt <= '0;
      KD_mode <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      state <= state_n;
      p <= p_n;
      k <= k_n;
      j <= j_n;
      valid <= valid_n;
      stage_last <= stage_last_n;
      cnt <= cnt_n;
      KD_mode <= kd_n;
      inv_q <= inv_n;
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign base = 4'd3 + (KD_mode ? 4'd2 : 4'd0) + (inv_q ? 4'd4 : 4'd0);

  always_comb begin
    Run_mode = 4'b0000;
    unique case (1'b1)
      (state == S_IDLE): Run_mode = 4'b0000;
      (state == S_DONE): Run_mode = base + 4'd1;
      default:           Run_mode = base;
    endcase
  end

endmodule
